// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB3 UART slave with TX/RX FIFOs, runtime baud divisor, parity, sticky errors and irq.
module apb_uart_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 87
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic [7:0] PADDR,
    input  logic       PWRITE,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       rx,
    output logic       tx,
    output logic       rx_done,
    output logic       tx_done,
    output logic       irq
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS);

    logic [6:0]       r_ctrl;
    logic [DIV_W-1:0] r_div;
    logic             w_acc, w_wr, w_rd;
    logic             w_sel_data, w_sel_stat, w_sel_ctrl, w_sel_divl, w_sel_divh, w_mapped;
    logic [DIV_W-1:0] w_div_eff;
    logic [15:0]      w_div16;
    logic [7:0]       w_status;
    logic             r_ovr, r_perr, r_ferr, r_irq;

    // index 0 is the TX FIFO, index 1 the RX FIFO
    logic [1:0]                w_fpush, w_fpop, w_ffull, w_fempty;
    logic [1:0][DATA_BITS-1:0] w_fin, w_fq;

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [AW-1:0]        r_wp, r_rp;
        logic [AW:0]          r_cnt;
        logic                 w_push, w_pop;
        assign w_fempty[g] = r_cnt == '0;
        assign w_ffull[g]  = r_cnt == (AW+1)'(FIFO_DEPTH);
        assign w_pop       = w_fpop[g] & ~w_fempty[g];
        assign w_push      = w_fpush[g] & (~w_ffull[g] | w_pop);
        assign w_fq[g]     = r_mem[r_rp];
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop) r_rp <= r_rp + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
        end
        always_ff @(posedge PCLK) if (w_push) r_mem[r_wp] <= w_fin[g];
    end

    assign w_acc      = PSEL & PENABLE;
    assign w_wr       = w_acc & PWRITE;
    assign w_rd       = w_acc & ~PWRITE;
    assign w_sel_data = PADDR == 8'h00;
    assign w_sel_stat = PADDR == 8'h04;
    assign w_sel_ctrl = PADDR == 8'h08;
    assign w_sel_divl = PADDR == 8'h0C;
    assign w_sel_divh = PADDR == 8'h10;
    assign w_mapped   = w_sel_data | w_sel_stat | w_sel_ctrl | w_sel_divl | w_sel_divh;
    assign w_div_eff  = (r_div < DIV_W'(4)) ? DIV_W'(4) : r_div;
    assign w_div16    = 16'(r_div);

    state_t               r_txs, r_rxs;
    logic                 r_tx, r_tx_done, r_tx_par, r_tx_pen, r_tx_stop2;
    logic [DIV_W-1:0]     r_tx_div, r_tx_cnt, r_rx_div, r_rx_cnt;
    logic [BW-1:0]        r_tx_bit, r_rx_bit;
    logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh;
    logic                 r_rx_s1, r_rx_s2, r_rx_prev, r_rx_pen, r_rx_odd, r_rx_perr, r_rx_done;
    logic                 w_tx_tick, w_rx_tick, w_rx_fall;

    assign w_status = {r_ferr, r_perr, r_ovr, r_txs != S_IDLE, w_fempty[1], w_ffull[1], w_fempty[0], w_ffull[0]};
    assign w_fpush  = {r_rx_done, w_wr & w_sel_data};
    assign w_fpop   = {w_rd & w_sel_data, (r_txs == S_IDLE) & r_ctrl[0] & ~w_fempty[0]};
    assign w_fin    = {r_rx_sh, PWDATA[DATA_BITS-1:0]};

    assign PREADY  = 1'b1;
    assign PRDATA  = !w_rd      ? 8'h00 :
                     w_sel_data ? (w_fempty[1] ? 8'h00 : 8'(w_fq[1])) :
                     w_sel_stat ? w_status :
                     w_sel_ctrl ? {1'b0, r_ctrl} :
                     w_sel_divl ? w_div16[7:0] :
                     w_sel_divh ? w_div16[15:8] : 8'h00;
    // a write that coincides with the TX pop still fits, so it is not an error
    assign PSLVERR = w_acc & (~w_mapped | (w_sel_data & (PWRITE ? w_ffull[0] & ~w_fpop[0] : w_fempty[1])));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ctrl <= 7'h03;
            r_div  <= DIV_W'(DEFAULT_DIV);
        end else if (w_wr) begin
            if (w_sel_ctrl) r_ctrl <= PWDATA[6:0];
            if (w_sel_divl) r_div[7:0] <= PWDATA;
            if (w_sel_divh) r_div <= DIV_W'({PWDATA, r_div[7:0]});
        end
    end

    assign w_tx_tick = r_tx_cnt == r_tx_div - DIV_W'(1);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_txs      <= S_IDLE;
            r_tx       <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_div   <= DIV_W'(4);
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_sh    <= '0;
            r_tx_par   <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_stop2 <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_txs == S_IDLE) begin
                if (w_fpop[0]) begin
                    r_txs      <= S_START;
                    r_tx       <= 1'b0;
                    r_tx_cnt   <= '0;
                    r_tx_sh    <= w_fq[0];
                    r_tx_par   <= ^w_fq[0] ^ r_ctrl[3];
                    r_tx_pen   <= r_ctrl[2];
                    r_tx_stop2 <= r_ctrl[4];
                    r_tx_div   <= w_div_eff;
                end
            end else if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt + DIV_W'(1);
            end else begin
                r_tx_cnt <= '0;
                case (r_txs)
                    S_START: begin
                        r_txs    <= S_DATA;
                        r_tx     <= r_tx_sh[0];
                        r_tx_bit <= '0;
                    end
                    S_DATA: if (r_tx_bit == BW'(DATA_BITS-1)) begin
                        r_txs    <= r_tx_pen ? S_PAR : S_STOP;
                        r_tx     <= r_tx_pen ? r_tx_par : 1'b1;
                        r_tx_bit <= '0;
                    end else begin
                        r_tx_bit <= r_tx_bit + BW'(1);
                        r_tx_sh  <= r_tx_sh >> 1;
                        r_tx     <= r_tx_sh[1];
                    end
                    S_PAR: begin
                        r_txs <= S_STOP;
                        r_tx  <= 1'b1;
                    end
                    default: if (r_tx_stop2 && r_tx_bit == '0) begin
                        r_tx_bit <= BW'(1);
                    end else begin
                        r_txs     <= S_IDLE;
                        r_tx_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_tick = r_rx_cnt == ((r_rxs == S_START) ? (r_rx_div >> 1) - DIV_W'(1) : r_rx_div - DIV_W'(1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rxs     <= S_IDLE;
            r_rx_div  <= DIV_W'(4);
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_pen  <= 1'b0;
            r_rx_odd  <= 1'b0;
            r_rx_perr <= 1'b0;
            r_rx_done <= 1'b0;
            r_ovr     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_done <= 1'b0;
            r_ovr     <= r_ovr & ~(w_wr & w_sel_stat & PWDATA[5]);
            r_perr    <= r_perr & ~(w_wr & w_sel_stat & PWDATA[6]);
            r_ferr    <= r_ferr & ~(w_wr & w_sel_stat & PWDATA[7]);
            if (r_rxs == S_IDLE) begin
                if (r_ctrl[1] && w_rx_fall) begin
                    r_rxs     <= S_START;
                    r_rx_cnt  <= '0;
                    r_rx_div  <= w_div_eff;
                    r_rx_pen  <= r_ctrl[2];
                    r_rx_odd  <= r_ctrl[3];
                    r_rx_perr <= 1'b0;
                end
            end else if (r_rxs == S_WAIT) begin
                if (r_rx_s2) r_rxs <= S_IDLE;
            end else if (!w_rx_tick) begin
                r_rx_cnt <= r_rx_cnt + DIV_W'(1);
            end else begin
                r_rx_cnt <= '0;
                case (r_rxs)
                    S_START: begin
                        r_rxs    <= r_rx_s2 ? S_IDLE : S_DATA;
                        r_rx_bit <= '0;
                    end
                    S_DATA: begin
                        r_rx_sh  <= {r_rx_s2, r_rx_sh[DATA_BITS-1:1]};
                        r_rx_bit <= r_rx_bit + BW'(1);
                        if (r_rx_bit == BW'(DATA_BITS-1)) r_rxs <= r_rx_pen ? S_PAR : S_STOP;
                    end
                    S_PAR: begin
                        r_rx_perr <= r_rx_s2 != (^r_rx_sh ^ r_rx_odd);
                        r_rxs     <= S_STOP;
                    end
                    default: if (!r_rx_s2) begin
                        r_ferr <= 1'b1;
                        r_rxs  <= S_WAIT;
                    end else begin
                        r_rxs <= S_IDLE;
                        if (r_rx_perr) r_perr <= 1'b1;
                        if (w_ffull[1]) r_ovr <= 1'b1;
                        else r_rx_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) r_irq <= 1'b0;
        else r_irq <= (r_ctrl[5] & ~w_fempty[1]) | (r_ctrl[6] & w_fempty[0]) | r_ovr | r_perr | r_ferr;
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;
    assign rx_done = r_rx_done;
    assign irq     = r_irq;
endmodule

// File: tb/tb_apb_uart_fifo.sv
// tb_apb_uart_fifo: directed scenarios for the APB UART with hand-computed expectations.
`timescale 1ns/1ps
module tb_apb_uart_fifo;
    logic       PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR, tx, rx_done, tx_done, irq;
    logic       rx_drv = 1'b1, loop = 1'b0;
    logic       rx;
    int         total = 0, bad = 0, n_txd = 0, n_rxd = 0;

    assign rx = loop ? tx : rx_drv;

    apb_uart_fifo dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .rx(rx), .tx(tx), .rx_done(rx_done), .tx_done(tx_done), .irq(irq)
    );

    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (tx_done) n_txd++;
        if (rx_done) n_rxd++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 e = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [7:0] d, output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #1 begin d = PRDATA; e = PSLVERR; end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            step(16);
        end
        rx_drv = 1'b1;
        step(16);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       e;
        PRESETn = 1'b0;
        step(3);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rst_tx got=%b exp=1", tx); end
        total++; if (PRDATA !== 8'h00 || PSLVERR !== 1'b0) begin bad++; $display("FAIL rst_apb got=%h/%b exp=00/0", PRDATA, PSLVERR); end
        total++; if ({rx_done, tx_done, irq} !== 3'b000) begin bad++; $display("FAIL rst_pulses got=%b exp=000", {rx_done, tx_done, irq}); end
        #2 PRESETn = 1'b1;
        step(2);
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL rst_status got=%h exp=0a", d); end
        apb_rd(8'h08, d, e);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL rst_ctrl got=%h exp=03", d); end
        apb_rd(8'h0C, d, e);
        total++; if (d !== 8'h57) begin bad++; $display("FAIL rst_divl got=%h exp=57", d); end
    endtask

    task automatic test_tx_frame();
        logic [9:0] bits;
        logic       e;
        int         k, base;
        bits = {1'b1, 8'hA5, 1'b0};
        apb_wr(8'h0C, 8'd16, e);
        apb_wr(8'h10, 8'd0, e);
        base = n_txd;
        apb_wr(8'h00, 8'hA5, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL tx_push_err got=%b exp=0", e); end
        k = 0;
        while (tx !== 1'b0 && k < 100) begin step(1); k++; end
        total++; if (k >= 100) begin bad++; $display("FAIL tx_start got=timeout exp=start"); end
        for (int i = 0; i < 10; i++) begin
            total++; if (tx !== bits[i]) begin bad++; $display("FAIL tx_bit%0d_first got=%b exp=%b", i, tx, bits[i]); end
            step(15);
            total++; if (tx !== bits[i]) begin bad++; $display("FAIL tx_bit%0d_last got=%b exp=%b", i, tx, bits[i]); end
            step(1);
        end
        step(5);
        total++; if (n_txd - base !== 1) begin bad++; $display("FAIL tx_done_cnt got=%0d exp=1", n_txd - base); end
    endtask

    task automatic test_loopback();
        logic [7:0] v [4];
        logic [7:0] d;
        logic       e;
        int         k, base;
        v = '{8'h00, 8'hFF, 8'h55, 8'h80};
        apb_wr(8'h08, 8'h2F, e);
        loop = 1'b1;
        base = n_rxd;
        for (int i = 0; i < 4; i++) apb_wr(8'h00, v[i], e);
        k = 0;
        while (n_rxd - base < 4 && k < 3000) begin step(1); k++; end
        total++; if (n_rxd - base !== 4) begin bad++; $display("FAIL lb_rx_count got=%0d exp=4", n_rxd - base); end
        step(2);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL lb_irq_set got=%b exp=1", irq); end
        apb_rd(8'h04, d, e);
        total++; if ((d & 8'hE8) !== 8'h00) begin bad++; $display("FAIL lb_flags got=%h exp=flags/rxempty clear", d); end
        for (int i = 0; i < 4; i++) begin
            apb_rd(8'h00, d, e);
            total++; if (d !== v[i] || e !== 1'b0) begin bad++; $display("FAIL lb_data%0d got=%h/%b exp=%h/0", i, d, e, v[i]); end
        end
        step(20);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL lb_irq_clr got=%b exp=0", irq); end
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL lb_status_end got=%h exp=0a", d); end
        loop = 1'b0;
    endtask

    task automatic test_tx_fifo_full();
        logic [7:0] d;
        logic       e, errs;
        int         k, base, tbase;
        apb_wr(8'h08, 8'h00, e);
        errs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            apb_wr(8'h00, 8'h10 + 8'(i), e);
            errs |= e;
        end
        total++; if (errs !== 1'b0) begin bad++; $display("FAIL full_fill_err got=%b exp=0", errs); end
        apb_wr(8'h00, 8'hEE, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL full_slverr got=%b exp=1", e); end
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h09) begin bad++; $display("FAIL full_status got=%h exp=09", d); end
        loop = 1'b1;
        base = n_rxd;
        tbase = n_txd;
        apb_wr(8'h08, 8'h03, e);
        k = 0;
        while (n_rxd - base < 8 && k < 3000) begin step(1); k++; end
        step(400);
        total++; if (n_txd - tbase !== 8) begin bad++; $display("FAIL drain_tx_count got=%0d exp=8", n_txd - tbase); end
        total++; if (n_rxd - base !== 8) begin bad++; $display("FAIL drain_rx_count got=%0d exp=8", n_rxd - base); end
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h06) begin bad++; $display("FAIL drain_status got=%h exp=06", d); end
        for (int i = 0; i < 8; i++) begin
            apb_rd(8'h00, d, e);
            total++; if (d !== 8'h10 + 8'(i)) begin bad++; $display("FAIL drain_data%0d got=%h exp=%h", i, d, 8'h10 + 8'(i)); end
        end
        loop = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       e;
        int         base;
        apb_wr(8'h08, 8'h02, e);
        base = n_rxd;
        for (int i = 0; i < 9; i++) send_rx(8'h30 + 8'(i), 1'b1);
        total++; if (n_rxd - base !== 8) begin bad++; $display("FAIL ovr_rx_count got=%0d exp=8", n_rxd - base); end
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h26) begin bad++; $display("FAIL ovr_status got=%h exp=26", d); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovr_irq got=%b exp=1", irq); end
        apb_wr(8'h04, 8'h20, e);
        step(2);
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h06) begin bad++; $display("FAIL ovr_clear got=%h exp=06", d); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ovr_irq_clr got=%b exp=0", irq); end
        for (int i = 0; i < 8; i++) begin
            apb_rd(8'h00, d, e);
            total++; if (d !== 8'h30 + 8'(i)) begin bad++; $display("FAIL ovr_data%0d got=%h exp=%h", i, d, 8'h30 + 8'(i)); end
        end
    endtask

    task automatic test_errors();
        logic [7:0] d;
        logic       e;
        int         base;
        base = n_rxd;
        send_rx(8'h5A, 1'b0);
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h8A) begin bad++; $display("FAIL frm_status got=%h exp=8a", d); end
        total++; if (n_rxd - base !== 0) begin bad++; $display("FAIL frm_nopush got=%0d exp=0", n_rxd - base); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL frm_irq got=%b exp=1", irq); end
        apb_wr(8'h04, 8'h80, e);
        rx_drv = 1'b0;
        step(1);
        rx_drv = 1'b1;
        step(60);
        total++; if (n_rxd - base !== 0) begin bad++; $display("FAIL glitch_nopush got=%0d exp=0", n_rxd - base); end
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL glitch_status got=%h exp=0a", d); end
        apb_rd(8'h00, d, e);
        total++; if (d !== 8'h00 || e !== 1'b1) begin bad++; $display("FAIL empty_read got=%h/%b exp=00/1", d, e); end
        apb_rd(8'h14, d, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b exp=1", e); end
    endtask

    task automatic test_reset_mid_tx();
        logic [7:0] d;
        logic       e;
        apb_wr(8'h08, 8'h01, e);
        apb_wr(8'h00, 8'h00, e);
        apb_wr(8'h00, 8'h11, e);
        apb_wr(8'h00, 8'h22, e);
        step(30);
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL midtx_low got=%b exp=0", tx); end
        #3 PRESETn = 1'b0;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_rst_tx got=%b exp=1", tx); end
        step(2);
        #2 PRESETn = 1'b1;
        step(2);
        apb_rd(8'h04, d, e);
        total++; if (d !== 8'h0A) begin bad++; $display("FAIL midtx_status got=%h exp=0a", d); end
        apb_rd(8'h08, d, e);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL midtx_ctrl got=%h exp=03", d); end
        apb_rd(8'h0C, d, e);
        total++; if (d !== 8'h57) begin bad++; $display("FAIL midtx_divl got=%h exp=57", d); end
        apb_rd(8'h10, d, e);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL midtx_divh got=%h exp=00", d); end
        step(50);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL midtx_idle got=%b exp=1", tx); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_tx_fifo_full();
        test_overrun();
        test_errors();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
